// File: rtl/iob_fifo_sync_thr_if.sv
// iob_fifo_sync_thr_if
//   Handshake/status bundle for iob_fifo_sync_thr. Signal names keep the
//   original port names of the FIFO.
//   master : the FIFO user (drives requests, data, thresholds, error clear)
//   slave  : the FIFO itself (drives data out, flags, level, error flags)
interface iob_fifo_sync_thr_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              w_en_i;
  logic [DATA_W-1:0] w_data_i;
  logic              w_full_o;
  logic              r_en_i;
  logic [DATA_W-1:0] r_data_o;
  logic              r_empty_o;
  logic [ADDR_W:0]   almost_full_lvl_i;
  logic [ADDR_W:0]   almost_empty_lvl_i;
  logic              almost_full_o;
  logic              almost_empty_o;
  logic              err_clr_i;
  logic              w_overflow_o;
  logic              r_underflow_o;
  logic [ADDR_W:0]   level_o;

  modport master (
    output w_en_i, w_data_i, r_en_i, almost_full_lvl_i, almost_empty_lvl_i,
           err_clr_i,
    input  w_full_o, r_data_o, r_empty_o, almost_full_o, almost_empty_o,
           w_overflow_o, r_underflow_o, level_o
  );

  modport slave (
    input  w_en_i, w_data_i, r_en_i, almost_full_lvl_i, almost_empty_lvl_i,
           err_clr_i,
    output w_full_o, r_data_o, r_empty_o, almost_full_o, almost_empty_o,
           w_overflow_o, r_underflow_o, level_o
  );
endinterface

// File: rtl/iob_fifo_sync_thr.sv
// iob_fifo_sync_thr
//   Single-clock FIFO, register-array storage, DEPTH = 2**ADDR_W words.
//   Runtime almost-full / almost-empty thresholds, full-range level count
//   (0..DEPTH) and sticky overflow / underflow flags.
// Ports:
//   clk_i  : clock, rising edge
//   arst_i : asynchronous active-high reset
//   rst_i  : synchronous active-high soft clear (pointers, level, flags, errors)
//   bus    : iob_fifo_sync_thr_if.slave (write/read handshake, data,
//            thresholds, status flags, level, error flags/clear)
// Build option:
//   IOB_FIFO_SYNC_FWFT_EN : first-word fall-through read data (combinational
//   r_data_o = mem[r_ptr]); otherwise registered read with 1-cycle latency.
module iob_fifo_sync_thr #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input logic               clk_i,
  input logic               arst_i,
  input logic               rst_i,
  iob_fifo_sync_thr_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] w_ptr, r_ptr;
  logic [ADDR_W:0]   level_q;
  logic [ADDR_W+1:0] level_nxt;
  logic              full_q, empty_q, afull_q, aempty_q;
  logic              ovf_q, unf_q;
  logic              w_en_int, r_en_int;

  assign w_en_int = bus.w_en_i & ~full_q;
  assign r_en_int = bus.r_en_i & ~empty_q;

  // One extra bit keeps the +1/-1 arithmetic and threshold compares exact.
  always_comb begin
    level_nxt = {1'b0, level_q} + (ADDR_W+2)'(w_en_int)
                - (ADDR_W+2)'(r_en_int);
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (w_en_int) mem[w_ptr] <= bus.w_data_i;
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      w_ptr    <= '0;
      r_ptr    <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
    end else if (rst_i) begin
      w_ptr    <= '0;
      r_ptr    <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
    end else begin
      if (w_en_int) w_ptr <= w_ptr + ADDR_W'(1);
      if (r_en_int) r_ptr <= r_ptr + ADDR_W'(1);
      level_q  <= level_nxt[ADDR_W:0];
      // Flags come from level_nxt so they line up with level_o each cycle.
      empty_q  <= (level_nxt == '0);
      full_q   <= (level_nxt == (ADDR_W+2)'(DEPTH));
      afull_q  <= (level_nxt >= {1'b0, bus.almost_full_lvl_i});
      aempty_q <= (level_nxt <= {1'b0, bus.almost_empty_lvl_i});
    end
  end

  // Sticky errors: a new event wins over a clear in the same cycle.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (rst_i) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (bus.w_en_i & full_q)  ovf_q <= 1'b1;
      else if (bus.err_clr_i)   ovf_q <= 1'b0;
      if (bus.r_en_i & empty_q) unf_q <= 1'b1;
      else if (bus.err_clr_i)   unf_q <= 1'b0;
    end
  end

`ifdef IOB_FIFO_SYNC_FWFT_EN
  assign bus.r_data_o = mem[r_ptr];
`else
  logic [DATA_W-1:0] r_data_q;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i)        r_data_q <= '0;
    else if (rst_i)    r_data_q <= '0;
    else if (r_en_int) r_data_q <= mem[r_ptr];
  end

  assign bus.r_data_o = r_data_q;
`endif

  assign bus.w_full_o       = full_q;
  assign bus.r_empty_o      = empty_q;
  assign bus.almost_full_o  = afull_q;
  assign bus.almost_empty_o = aempty_q;
  assign bus.w_overflow_o   = ovf_q;
  assign bus.r_underflow_o  = unf_q;
  assign bus.level_o        = level_q;
endmodule

// File: tb/tb_iob_fifo_sync_thr.sv
module tb_iob_fifo_sync_thr;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 2;
  localparam int DEPTH  = 4;

  logic clk_i  = 1'b0;
  logic arst_i = 1'b0;
  logic rst_i  = 1'b0;

  iob_fifo_sync_thr_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  iob_fifo_sync_thr #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk_i  (clk_i),
    .arst_i (arst_i),
    .rst_i  (rst_i),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  // Reference model: a queue of stored words plus the sticky error bits.
  logic [DATA_W-1:0] q[$];
  logic              m_ovf = 1'b0;
  logic              m_unf = 1'b0;
  logic [DATA_W-1:0] m_rdata = '0;
  logic              m_srst = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state();
    chk("rst_level", 32'(bus.level_o), 0);
    chk("rst_empty", 32'(bus.r_empty_o), 1);
    chk("rst_full", 32'(bus.w_full_o), 0);
    chk("rst_aempty", 32'(bus.almost_empty_o), 1);
    chk("rst_afull", 32'(bus.almost_full_o), 0);
    chk("rst_ovf", 32'(bus.w_overflow_o), 0);
    chk("rst_unf", 32'(bus.r_underflow_o), 0);
`ifndef IOB_FIFO_SYNC_FWFT_EN
    chk("rst_rdata", 32'(bus.r_data_o), 0);
`endif
  endtask

  task automatic model_clear();
    q.delete();
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
    m_rdata = '0;
  endtask

  task automatic check_all();
    int sz = q.size();
    chk("level", 32'(bus.level_o), 32'(sz));
    chk("empty", 32'(bus.r_empty_o), 32'(sz == 0));
    chk("full", 32'(bus.w_full_o), 32'(sz == DEPTH));
    chk("aempty", 32'(bus.almost_empty_o),
        32'(sz <= int'(bus.almost_empty_lvl_i)));
    chk("afull", 32'(bus.almost_full_o),
        m_srst ? 32'd0 : 32'(sz >= int'(bus.almost_full_lvl_i)));
    chk("ovf", 32'(bus.w_overflow_o), 32'(m_ovf));
    chk("unf", 32'(bus.r_underflow_o), 32'(m_unf));
`ifdef IOB_FIFO_SYNC_FWFT_EN
    if (sz > 0) chk("rdata_fwft", 32'(bus.r_data_o), 32'(q[0]));
`else
    chk("rdata", 32'(bus.r_data_o), 32'(m_rdata));
`endif
  endtask

  // One clock: apply inputs, advance the model, check after the edge.
  task automatic step(input logic w, input logic [DATA_W-1:0] d,
                      input logic r, input logic clr, input logic srst);
    logic was_full, was_empty;
    bus.w_en_i    = w;
    bus.w_data_i  = d;
    bus.r_en_i    = r;
    bus.err_clr_i = clr;
    rst_i         = srst;
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    @(posedge clk_i);
    #1;
    m_srst = srst;
    if (srst) begin
      model_clear();
    end else begin
      if (r && !was_empty) m_rdata = q.pop_front();
      if (w && !was_full)  q.push_back(d);
      if (w && was_full) m_ovf = 1'b1; else if (clr) m_ovf = 1'b0;
      if (r && was_empty) m_unf = 1'b1; else if (clr) m_unf = 1'b0;
    end
    check_all();
  endtask

  task automatic do_arst();
    #2 arst_i = 1'b1;
    #1;
    model_clear();
    chk_reset_state();
    #2 arst_i = 1'b0;
  endtask

  initial begin
    bus.w_en_i             = 1'b0;
    bus.w_data_i           = '0;
    bus.r_en_i             = 1'b0;
    bus.err_clr_i          = 1'b0;
    bus.almost_full_lvl_i  = 3'd3;
    bus.almost_empty_lvl_i = 3'd1;

    #2 arst_i = 1'b1;
    #1 chk_reset_state();
    #4 arst_i = 1'b0;
    model_clear();

    // Fill to full, then read back in order.
    step(1, 8'h11, 0, 0, 0);
    step(1, 8'h22, 0, 0, 0);
    step(1, 8'h33, 0, 0, 0);
    step(1, 8'h44, 0, 0, 0);
    // Overflow attempt is dropped; flag sticks until cleared.
    step(1, 8'h55, 0, 0, 0);
    step(0, 8'h00, 0, 0, 0);
    step(0, 8'h00, 0, 0, 0);
    step(0, 8'h00, 0, 1, 0);
    // Write while full with simultaneous read: only the read happens.
    step(1, 8'h66, 1, 0, 0);
    step(1, 8'h77, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0, 0);
    // Underflow on empty FIFO; level stays zero.
    step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 0, 0, 0);
    step(0, 8'h00, 1, 1, 0);   // new event beats clear
    step(0, 8'h00, 0, 1, 0);
    // Read while empty with simultaneous write: level becomes 1.
    step(1, 8'h88, 1, 0, 0);
    // Hold level at 2 with simultaneous read/write, wrapping pointers.
    step(1, 8'h99, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 8'(i), 1, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 1, 0, 0);

    // Async reset in the middle of operation, then fresh traffic.
    step(1, 8'hA1, 0, 0, 0);
    step(1, 8'hA2, 0, 0, 0);
    step(1, 8'hA3, 0, 0, 0);
    do_arst();
    step(1, 8'hB4, 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);

    // Sync soft clear with data stored.
    step(1, 8'hC1, 0, 0, 0);
    step(1, 8'hC2, 0, 0, 0);
    step(0, 8'h00, 0, 0, 1);
    step(1, 8'hC3, 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);

    // Randomized traffic with shifting thresholds and write/read bias.
    for (int i = 0; i < 600; i++) begin
      int bias;
      if (i % 40 == 0) begin
        bus.almost_full_lvl_i  = 3'($urandom_range(0, 5));
        bus.almost_empty_lvl_i = 3'($urandom_range(0, 5));
      end
      bias = (i / 60) % 3;
      step(($urandom_range(0, 3) < 32'(1 + bias)),
           8'($urandom),
           ($urandom_range(0, 3) < 32'(3 - bias)),
           ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 99) == 0));
      if (i == 300) do_arst();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/iob_fifo_sync_thr.md
Name: iob_fifo_sync_thr

Overview:
Synchronous single-clock FIFO with internal register-array storage. Adds runtime almost-full/almost-empty thresholds, a full-range level count and sticky overflow/underflow error flags. Used as the general buffering primitive between streaming peripherals and the CPU-side register interface, where software programs watermarks for interrupt generation.

Parameters:
DATA_W, 8, word width in bits (>=1)
ADDR_W, 4, address width; depth DEPTH = 2**ADDR_W words (>=1)

Ports:
clk_i  input  1  clock; all logic on rising edge
arst_i  input  1  asynchronous active-high reset
rst_i  input  1  synchronous active-high soft clear (pointers, level, flags, errors)
w_en_i  input  1  write request
w_data_i  input  DATA_W  write data
w_full_o  output  1  FIFO full (level == DEPTH)
r_en_i  input  1  read request
r_data_o  output  DATA_W  read data
r_empty_o  output  1  FIFO empty (level == 0)
almost_full_lvl_i  input  ADDR_W+1  almost-full threshold
almost_empty_lvl_i  input  ADDR_W+1  almost-empty threshold
almost_full_o  output  1  level >= almost_full_lvl_i
almost_empty_o  output  1  level <= almost_empty_lvl_i
err_clr_i  input  1  clears sticky error flags
w_overflow_o  output  1  sticky: write attempted while full
r_underflow_o  output  1  sticky: read attempted while empty
level_o  output  ADDR_W+1  words stored, 0..DEPTH

Behaviour:
- Reset (arst_i async, or rst_i sync): pointers=0, level_o=0, r_empty_o=1, w_full_o=0, almost_empty_o=1, almost_full_o=(almost_full_lvl_i==0 ? 1 : 0) after first clock (registered; reset value 0), w_overflow_o=0, r_underflow_o=0, r_data_o=0. Memory contents are not cleared.
- Effective enables: w_en_int = w_en_i & ~w_full_o; r_en_int = r_en_i & ~r_empty_o.
- Write: on w_en_int, mem[w_ptr] <= w_data_i; w_ptr increments mod DEPTH (natural wrap).
- Read (default mode): on r_en_int, r_data_o <= mem[r_ptr] (1-cycle latency, registered output, holds value otherwise); r_ptr increments mod DEPTH.
- Level: level_nxt = level + w_en_int - r_en_int, computed in ADDR_W+2 bits; level_o registered. Simultaneous accepted read and write leaves level unchanged.
- Flags registered from level_nxt, so they always match level_o in the same cycle: r_empty_o = (level_nxt==0); w_full_o = (level_nxt==DEPTH); almost_full_o = (level_nxt >= almost_full_lvl_i); almost_empty_o = (level_nxt <= almost_empty_lvl_i). Thresholds are sampled every cycle; changing them updates the flags on the next edge.
- Write while full with simultaneous read: write is rejected (uses current w_full_o), read proceeds, level decrements. Read while empty with simultaneous write: read rejected, write proceeds, level becomes 1.
- Errors: w_overflow_o set on w_en_i & w_full_o; r_underflow_o set on r_en_i & r_empty_o. Sticky until err_clr_i, rst_i or arst_i. Set takes priority over err_clr_i in the same cycle.
- Same-address read and write never occur in the default mode, because a full FIFO blocks writes and an empty FIFO blocks reads.
- arst_i mid-operation: immediate return to reset state; data in flight is lost.

Optional Feature:
IOB_FIFO_SYNC_FWFT_EN: first-word fall-through. When defined, r_data_o = mem[r_ptr] combinationally and is valid whenever r_empty_o=0; r_en_int pops the word and the next word appears in the same cycle the pointer advances. Flag and level timing are unchanged. When undefined, the registered 1-cycle-latency read described above applies.

Test Plan:
DATA_W=8, ADDR_W=2. Write 0x11,0x22,0x33,0x44 -> level_o 1,2,3,4; w_full_o=1 after 4th edge; read 4 -> data 0x11..0x44 in order, one cycle after each r_en_i; r_empty_o=1 at end.
Full FIFO, w_en_i=1 with data 0x55 -> write ignored, w_overflow_o=1 and stays 1 until err_clr_i pulse; an empty FIFO with r_en_i=1 -> r_underflow_o=1, level_o stays 0.
Level 2, simultaneous w_en_i and r_en_i for 10 cycles with data 0..9 -> level_o stays 2; pointers wrap and read order is preserved.
almost_full_lvl_i=3, almost_empty_lvl_i=1: fill 0->4 -> almost_empty_o=1 at levels 0,1; almost_full_o=1 at levels 3,4.
Write 3 words, assert arst_i mid-cycle -> all outputs reach reset values asynchronously; a subsequent write/read returns the new data.
With IOB_FIFO_SYNC_FWFT_EN defined: write 0xA5 -> r_data_o=0xA5 in the cycle r_empty_o falls; r_en_i pops it with no added latency.
